div32: RTL and testbench
========================

# div32

Iterative 32-bit integer divider for the CPU datapath: signed and unsigned division via radix-2 restoring shift-subtract, one quotient bit per clock.
- It is the multi-cycle counterpart to the single-cycle adder: it uses repeated subtraction, where the adder performs one-cycle addition.
- It sits beside the ALU and is driven by the control unit through a start/busy/done handshake.
- Quotient and remainder are held in output registers until the next division completes.

## Interface
Parameters:
- WIDTH, 32, operand/result width; only 32 is supported by this spec.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request; accepted only when busy=0
- is_signed  in  1  1 = two's-complement division, 0 = unsigned; sampled with start
- dividend  in  32  sampled with start
- divisor  in  32  sampled with start
- busy  out  1  high while a division is in progress
- done  out  1  one-cycle pulse; results valid from this cycle on
- quotient  out  32  registered result
- remainder  out  32  registered result
- div_zero  out  1  registered; 1 if the completed division had divisor=0

## Operation
States:
- IDLE: busy=0.
  - start=1 latches the operands and is_signed and loads count=0.
  - If signed, it also latches the operand magnitudes (abs) and the sign flags: neg_q = sign(dividend) XOR sign(divisor), neg_r = sign(dividend).
  - Next state RUN.
- RUN: busy=1. Per cycle:
  - {rem,quo} shifts left 1 with the dividend MSB entering.
  - A trial subtraction rem - divisor_mag uses a 33-bit difference. If it is non-negative, rem takes the difference and the quo LSB is 1; otherwise rem is kept and the LSB is 0.
  - count increments. After the 32nd iteration, next state FIN.
- FIN: busy=1, for one cycle.
  - Sign correction is applied: negate quo if neg_q, negate rem if neg_r.
  - quotient, remainder and div_zero are written; done is set for the next cycle.
  - Next state IDLE.

Output behaviour:
- done is high in the first IDLE cycle after FIN.
- start during busy=1 is ignored and has no side effects.
- start in the done cycle is accepted, so back-to-back operation is allowed.

Special cases:
- Divisor 0: the iterations still run for uniform latency. Results are forced to quotient=0xFFFFFFFF and remainder=dividend (original, uncorrected), with div_zero=1, regardless of is_signed.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0, div_zero=0. This falls out of the magnitude path and wraps naturally.
- Unsigned operands are used as-is. Magnitude 0x80000000 is representable in 32 bits unsigned.

Reset:
- rst=1 forces state IDLE, count=0, busy=0, done=0, quotient=0, remainder=0, div_zero=0 at the next edge.
- Reset mid-operation aborts the division with no done pulse; it overrides a simultaneous start.

## Timing
- Start accepted at edge E0. busy is high from E0 through the cycle before E33 (33 cycles).
- RUN spans edges E1..E32; FIN register write happens at E33.
- done=1 and the new results are visible in the cycle after E33; busy=0 in that same cycle.
- Latency from start to done is 34 edges counted from the accepting edge, i.e. done is asserted 33 cycles after the start cycle. Latency is fixed for all operands, including divisor 0.
- Results remain stable through the next operation until its FIN edge.
- Maximum throughput is one division per 34 cycles.

## Test plan
- Unsigned 100 / 7, is_signed=0 -> quotient=14, remainder=2, div_zero=0; done exactly 33 cycles after the start cycle.
- Signed -7 / 2 (0xFFFFFFF9 / 0x2) -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Also 7 / -2 -> quotient=0xFFFFFFFD, remainder=1.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0. Unsigned 0xFFFFFFFF / 1 -> quotient=0xFFFFFFFF, remainder=0.
- 1234 / 0, both signedness settings -> quotient=0xFFFFFFFF, remainder=1234, div_zero=1, same latency.
- Handshake:
  - start pulsed mid-RUN with different operands -> ignored; original result delivered.
  - start in the done cycle -> second result delivered 34 cycles later.
  - Prior results stay stable during the second operation.
- rst asserted at iteration 10 together with start=1 -> next cycle busy=0, done=0, all outputs 0; no done pulse follows.

Source files
------------

// File: rtl/div32.sv
// div32 - iterative 32-bit integer divider (radix-2 restoring shift-subtract)
//
// Produces one quotient bit per clock. A division accepted at edge E0 runs
// 32 iterations on edges E1..E32, applies sign correction and writes the
// result registers at E33. done pulses in the following cycle.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   start      request, accepted only while busy=0
//   is_signed  1 = two's-complement, 0 = unsigned (sampled with start)
//   dividend   dividend operand (sampled with start)
//   divisor    divisor operand (sampled with start)
//   busy       high while a division is in progress
//   done       one-cycle pulse, results valid from this cycle on
//   quotient   registered quotient
//   remainder  registered remainder
//   div_zero   registered flag, last completed division had divisor=0

module div32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [5:0]       LAST_IT  = 6'(WIDTH - 1);

    // Two's-complement negation.
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        negate = ~v + ONE;
    endfunction

    // Magnitude of a signed value; 0x80000000 maps onto itself, which is
    // still correct when read as unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        magnitude = v[WIDTH-1] ? negate(v) : v;
    endfunction

    logic [1:0]       state;
    logic [5:0]       count;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dmag;
    logic [WIDTH-1:0] dvd_orig;
    logic             neg_q;
    logic             neg_r;
    logic             zero_div;

    logic [WIDTH:0]   shifted;
    logic             fits;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] quo_fin;
    logic [WIDTH-1:0] rem_fin;

    // One restoring iteration plus the final sign correction.
    always_comb begin
        shifted  = {rem, quo[WIDTH-1]};
        fits     = (shifted >= {1'b0, dmag});
        // When the trial succeeds the true difference is below dmag, so the
        // low WIDTH bits of the modular subtraction are exact.
        if (fits) begin
            rem_next = shifted[WIDTH-1:0] - dmag;
        end else begin
            rem_next = shifted[WIDTH-1:0];
        end
        quo_next = {quo[WIDTH-2:0], fits};
        if (neg_q) begin
            quo_fin = negate(quo);
        end else begin
            quo_fin = quo;
        end
        if (neg_r) begin
            rem_fin = negate(rem);
        end else begin
            rem_fin = rem;
        end
    end

    // Control FSM, iteration datapath and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= 6'd0;
            quo       <= {WIDTH{1'b0}};
            rem       <= {WIDTH{1'b0}};
            dmag      <= {WIDTH{1'b0}};
            dvd_orig  <= {WIDTH{1'b0}};
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            zero_div  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= {WIDTH{1'b0}};
            remainder <= {WIDTH{1'b0}};
            div_zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        count    <= 6'd0;
                        rem      <= {WIDTH{1'b0}};
                        dvd_orig <= dividend;
                        zero_div <= (divisor == {WIDTH{1'b0}});
                        if (is_signed) begin
                            quo   <= magnitude(dividend);
                            dmag  <= magnitude(divisor);
                            neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            neg_r <= dividend[WIDTH-1];
                        end else begin
                            quo   <= dividend;
                            dmag  <= divisor;
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    rem   <= rem_next;
                    quo   <= quo_next;
                    count <= count + 6'd1;
                    if (count == LAST_IT) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    // Divide-by-zero overrides whatever the iterations produced.
                    if (zero_div) begin
                        quotient  <= ALL_ONES;
                        remainder <= dvd_orig;
                    end else begin
                        quotient  <= quo_fin;
                        remainder <= rem_fin;
                    end
                    div_zero <= zero_div;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div32.sv
// tb_div32 - directed self-checking testbench for div32.
module tb_div32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] dividend = 32'd0;
    logic [31:0] divisor = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_zero;

    int passed = 0;
    int total  = 0;

    logic [31:0] prev_q = 32'd0;
    logic [31:0] prev_r = 32'd0;

    div32 #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called 1 time unit after a rising edge; returns 1 time unit after the accepting edge.
    task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b);
        is_signed = s;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges until done is seen; -1 if it never comes. Also checks that
    // the previous results hold while the operation is running.
    task automatic wait_done(input string tag, output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (i == 16) begin
                chk({tag, "_hold_q"}, quotient, prev_q);
                chk({tag, "_hold_r"}, remainder, prev_r);
                chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
            end
            if (done) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic run_check(input string tag, input logic s, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] q,
                             input logic [31:0] r, input logic dz);
        int n;
        start_op(s, a, b);
        wait_done(tag, n);
        chk({tag, "_lat"}, 32'(n), 32'd33);
        chk({tag, "_q"}, quotient, q);
        chk({tag, "_r"}, remainder, r);
        chk({tag, "_dz"}, {31'd0, div_zero}, {31'd0, dz});
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
        prev_q = q;
        prev_r = r;
    endtask

    initial begin
        int n;
        int pulses;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_q", quotient, 32'd0);
        chk("rst_r", remainder, 32'd0);
        chk("rst_dz", {31'd0, div_zero}, 32'd0);

        run_check("u100_7",   1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0);
        run_check("s_m7_2",   1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0);
        run_check("s_7_m2",   1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0);
        run_check("s_ovf",    1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0);
        run_check("u_max_1",  1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0);
        run_check("u_bigdiv", 1'b0, 32'hFFFFFFFF,   32'h80000001,   32'd1,          32'h7FFFFFFE,   1'b0);
        run_check("u_dz",     1'b0, 32'd1234,       32'd0,          32'hFFFFFFFF,   32'd1234,       1'b1);
        run_check("s_dz",     1'b1, 32'd1234,       32'd0,          32'hFFFFFFFF,   32'd1234,       1'b1);

        // start mid-run with other operands must be ignored
        start_op(1'b0, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #1;
        is_signed = 1'b1;
        dividend  = 32'd50;
        divisor   = 32'd5;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                n = i;
                break;
            end
        end
        chk("ign_lat", 32'(n), 32'd22);
        chk("ign_q", quotient, 32'd14);
        chk("ign_r", remainder, 32'd2);
        prev_q = 32'd14;
        prev_r = 32'd2;

        // back-to-back: start issued in the done cycle of the previous op
        start_op(1'b1, 32'hFFFFFFF9, 32'd2);
        wait_done("b2b", n);
        chk("b2b_lat34", 32'(n + 1), 32'd34);
        chk("b2b_q", quotient, 32'hFFFFFFFD);
        chk("b2b_r", remainder, 32'hFFFFFFFF);
        prev_q = 32'hFFFFFFFD;
        prev_r = 32'hFFFFFFFF;

        // reset at iteration 10 together with start
        start_op(1'b0, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        rst       = 1'b1;
        start     = 1'b1;
        dividend  = 32'd77;
        divisor   = 32'd3;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_q", quotient, 32'd0);
        chk("abort_r", remainder, 32'd0);
        chk("abort_dz", {31'd0, div_zero}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) pulses++;
        end
        chk("abort_quiet", 32'(pulses), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
